// File: rtl/fhg_spu_eject_sink.sv
// Terminating sink for a router Eject port: accepts every flit, counts flits/packets, latches first source ID.
// Optional head-flit source-ID log FIFO enabled by defining FHG_SPU_EJECT_SINK_LOG_EN.
module fhg_spu_eject_sink #(
   parameter int unsigned FlitWidth  = 64,
   parameter int unsigned SrcIdLsb   = 0,
   parameter int unsigned SrcIdWidth = 8,
   parameter int unsigned CntWidth   = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flit_valid_i,
   output logic                  flit_ready_o,
   input  logic [FlitWidth-1:0]  flit_data_i,
   input  logic                  flit_last_i,
   input  logic                  clear_i,
   output logic [CntWidth-1:0]   flit_cnt_o,
   output logic [CntWidth-1:0]   pkt_cnt_o,
   output logic                  err_o,
   output logic [SrcIdWidth-1:0] first_src_o,
   output logic                  in_pkt_o
`ifdef FHG_SPU_EJECT_SINK_LOG_EN
   ,
   output logic                  log_valid_o,
   input  logic                  log_ready_i,
   output logic [SrcIdWidth-1:0] log_src_o,
   output logic                  log_ovf_o
`endif
);

   typedef enum logic {ST_IDLE, ST_BODY} state_t;

   state_t                  state_reg, state_next;
   logic                    ready_reg;
   logic [CntWidth-1:0]     flit_cnt_reg, pkt_cnt_reg;
   logic                    err_reg;
   logic [SrcIdWidth-1:0]   first_src_reg;
   logic                    accept, head;
   logic [SrcIdWidth-1:0]   src_id;
   logic                    unused_data;

   assign accept = flit_valid_i & ready_reg;
   assign head   = accept & (state_reg == ST_IDLE);
   assign src_id = flit_data_i[SrcIdLsb +: SrcIdWidth];
   // Only the source-ID field of the payload is inspected.
   assign unused_data = ^flit_data_i;

   always_comb begin
      state_next = state_reg;
      if (clear_i) begin
         state_next = ST_IDLE;
      end else if (accept) begin
         state_next = flit_last_i ? ST_IDLE : ST_BODY;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg     <= ST_IDLE;
         ready_reg     <= 1'b0;
         flit_cnt_reg  <= '0;
         pkt_cnt_reg   <= '0;
         err_reg       <= 1'b0;
         first_src_reg <= '0;
      end else begin
         state_reg <= state_next;
         ready_reg <= 1'b1;
         if (clear_i) begin
            flit_cnt_reg  <= '0;
            pkt_cnt_reg   <= '0;
            err_reg       <= 1'b0;
            first_src_reg <= '0;
         end else if (accept) begin
            // Counters stick at all-ones rather than wrapping.
            if (flit_cnt_reg != '1) flit_cnt_reg <= flit_cnt_reg + 1'b1;
            if (flit_last_i && (pkt_cnt_reg != '1)) pkt_cnt_reg <= pkt_cnt_reg + 1'b1;
            if (head && !err_reg) begin
               err_reg       <= 1'b1;
               first_src_reg <= src_id;
            end
         end
      end
   end

   assign flit_ready_o = ready_reg;
   assign flit_cnt_o   = flit_cnt_reg;
   assign pkt_cnt_o    = pkt_cnt_reg;
   assign err_o        = err_reg;
   assign first_src_o  = first_src_reg;
   assign in_pkt_o     = (state_reg == ST_BODY);

`ifdef FHG_SPU_EJECT_SINK_LOG_EN
   logic [SrcIdWidth-1:0] log_mem [4];
   logic [1:0]            wr_ptr_reg, rd_ptr_reg;
   logic [2:0]            count_reg;
   logic                  ovf_reg;
   logic                  log_push, log_pop, log_full, log_write;

   assign log_push  = head & ~clear_i;
   assign log_pop   = (count_reg != 3'd0) & log_ready_i & ~clear_i;
   assign log_full  = (count_reg == 3'd4);
   // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
   assign log_write = log_push & (~log_full | log_pop);

   always_ff @(posedge clk_i) begin
      if (log_write) log_mem[wr_ptr_reg] <= src_id;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         ovf_reg    <= 1'b0;
      end else if (clear_i) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         ovf_reg    <= 1'b0;
      end else begin
         if (log_write) wr_ptr_reg <= wr_ptr_reg + 2'd1;
         if (log_pop)   rd_ptr_reg <= rd_ptr_reg + 2'd1;
         if (log_write && !log_pop)      count_reg <= count_reg + 3'd1;
         else if (!log_write && log_pop) count_reg <= count_reg - 3'd1;
         if (log_push && !log_write) ovf_reg <= 1'b1;
      end
   end

   assign log_valid_o = (count_reg != 3'd0);
   assign log_src_o   = log_mem[rd_ptr_reg];
   assign log_ovf_o   = ovf_reg;
`endif

endmodule

// File: tb/tb_fhg_spu_eject_sink.sv
// Self-checking bench for fhg_spu_eject_sink: directed scenarios plus random traffic against a queue-based model.
// Two instances share stimulus: default 16-bit counters and a 4-bit counter variant for saturation.
module tb_fhg_spu_eject_sink;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid = 1'b0;
   logic [63:0] data = '0;
   logic        last = 1'b0;
   logic        clear = 1'b0;
   logic        log_ready = 1'b0;

   logic        ready_a, err_a, in_pkt_a;
   logic [15:0] flit_a, pkt_a;
   logic [7:0]  first_a;
   logic        ready_b, err_b, in_pkt_b;
   logic [3:0]  flit_b, pkt_b;
   logic [7:0]  first_b;
`ifdef FHG_SPU_EJECT_SINK_LOG_EN
   logic        lv_a, lo_a, lv_b, lo_b;
   logic [7:0]  ls_a, ls_b;
`endif

   always #5 clk = ~clk;

   fhg_spu_eject_sink #(.FlitWidth(64), .SrcIdLsb(0), .SrcIdWidth(8), .CntWidth(16)) dut (
      .clk_i(clk), .rst_ni(rst_n), .flit_valid_i(valid), .flit_ready_o(ready_a),
      .flit_data_i(data), .flit_last_i(last), .clear_i(clear),
      .flit_cnt_o(flit_a), .pkt_cnt_o(pkt_a), .err_o(err_a), .first_src_o(first_a),
      .in_pkt_o(in_pkt_a)
`ifdef FHG_SPU_EJECT_SINK_LOG_EN
      , .log_valid_o(lv_a), .log_ready_i(log_ready), .log_src_o(ls_a), .log_ovf_o(lo_a)
`endif
   );

   fhg_spu_eject_sink #(.FlitWidth(64), .SrcIdLsb(0), .SrcIdWidth(8), .CntWidth(4)) dut4 (
      .clk_i(clk), .rst_ni(rst_n), .flit_valid_i(valid), .flit_ready_o(ready_b),
      .flit_data_i(data), .flit_last_i(last), .clear_i(clear),
      .flit_cnt_o(flit_b), .pkt_cnt_o(pkt_b), .err_o(err_b), .first_src_o(first_b),
      .in_pkt_o(in_pkt_b)
`ifdef FHG_SPU_EJECT_SINK_LOG_EN
      , .log_valid_o(lv_b), .log_ready_i(log_ready), .log_src_o(ls_b), .log_ovf_o(lo_b)
`endif
   );

   // Reference model: raw (unsaturated) counts, saturation applied at compare time.
   int       n_cmp = 0;
   int       n_err = 0;
   bit       m_ready = 0;
   int       m_flits = 0;
   int       m_pkts = 0;
   bit       m_err = 0;
   bit [7:0] m_first = 0;
   bit       m_inpkt = 0;
   bit [7:0] m_q[$];
   bit       m_ovf = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int v, input int max);
      return (v > max) ? max : v;
   endfunction

   task automatic check_all();
      chk("ready",     {31'd0, ready_a},  {31'd0, m_ready});
      chk("flit_cnt",  {16'd0, flit_a},   sat(m_flits, 65535));
      chk("pkt_cnt",   {16'd0, pkt_a},    sat(m_pkts, 65535));
      chk("err",       {31'd0, err_a},    {31'd0, m_err});
      chk("first_src", {24'd0, first_a},  {24'd0, m_first});
      chk("in_pkt",    {31'd0, in_pkt_a}, {31'd0, m_inpkt});
      chk("ready4",    {31'd0, ready_b},  {31'd0, m_ready});
      chk("flit_cnt4", {28'd0, flit_b},   sat(m_flits, 15));
      chk("pkt_cnt4",  {28'd0, pkt_b},    sat(m_pkts, 15));
      chk("err4",      {31'd0, err_b},    {31'd0, m_err});
      chk("first4",    {24'd0, first_b},  {24'd0, m_first});
      chk("in_pkt4",   {31'd0, in_pkt_b}, {31'd0, m_inpkt});
`ifdef FHG_SPU_EJECT_SINK_LOG_EN
      chk("log_valid", {31'd0, lv_a}, {31'd0, m_q.size() > 0});
      chk("log_ovf",   {31'd0, lo_a}, {31'd0, m_ovf});
      chk("log_valid4", {31'd0, lv_b}, {31'd0, m_q.size() > 0});
      if (m_q.size() > 0) begin
         chk("log_src",  {24'd0, ls_a}, {24'd0, m_q[0]});
         chk("log_src4", {24'd0, ls_b}, {24'd0, m_q[0]});
      end
`endif
   endtask

   task automatic model_reset();
      m_ready = 0; m_flits = 0; m_pkts = 0; m_err = 0; m_first = 0; m_inpkt = 0;
      m_q.delete(); m_ovf = 0;
   endtask

   // Apply the current inputs for one clock edge to the model, then compare.
   task automatic cycle();
      bit acc;
      bit pop;
      acc = valid && m_ready;
      pop = 0;
`ifdef FHG_SPU_EJECT_SINK_LOG_EN
      pop = log_ready && (m_q.size() > 0);
`endif
      if (clear) begin
         m_flits = 0; m_pkts = 0; m_err = 0; m_first = 0; m_inpkt = 0;
         m_q.delete(); m_ovf = 0;
      end else begin
         if (pop) void'(m_q.pop_front());
         if (acc) begin
            if (!m_inpkt) begin
               if (!m_err) begin
                  m_err = 1;
                  m_first = data[7:0];
               end
               if (m_q.size() < 4) m_q.push_back(data[7:0]);
               else m_ovf = 1;
            end
            m_flits++;
            if (last) m_pkts++;
            m_inpkt = !last;
         end
      end
      m_ready = 1;
      @(posedge clk);
      #1;
      check_all();
      $display("cyc v=%0b last=%0b clr=%0b src=%02h flits=%0d pkts=%0d err=%0b first=%02h in_pkt=%0b",
               valid, last, clear, data[7:0], flit_a, pkt_a, err_a, first_a, in_pkt_a);
   endtask

   task automatic send(input logic [7:0] src, input logic is_last, input logic clr);
      data  = {$urandom, $urandom};
      data[7:0] = src;
      valid = 1'b1;
      last  = is_last;
      clear = clr;
      cycle();
      valid = 1'b0;
      last  = 1'b0;
      clear = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      // 1: reset, then idle
      model_reset();
      #12;
      check_all();
      rst_n = 1'b1;
      idle(10);

      // 2: 3-flit packet 0x12 then single-flit 0x34
      send(8'h12, 1'b0, 1'b0);
      send(8'h99, 1'b0, 1'b0);
      send(8'h98, 1'b1, 1'b0);
      send(8'h34, 1'b1, 1'b0);
      chk("t2_flits", {16'd0, flit_a}, 32'd4);
      chk("t2_pkts",  {16'd0, pkt_a},  32'd2);
      chk("t2_first", {24'd0, first_a}, 32'h12);

      // 3: saturation of the 4-bit counters
      clear = 1'b1; cycle(); clear = 1'b0;
      for (int i = 0; i < 20; i++) send(8'($urandom), 1'b1, 1'b0);
      chk("t3_flit4", {28'd0, flit_b}, 32'd15);
      chk("t3_pkt4",  {28'd0, pkt_b},  32'd15);

      // 4: clear on the accepted last flit wins
      send(8'h56, 1'b0, 1'b0);
      send(8'h00, 1'b0, 1'b0);
      send(8'h01, 1'b1, 1'b1);
      chk("t4_flits", {16'd0, flit_a}, 32'd0);
      chk("t4_err",   {31'd0, err_a},  32'd0);
      send(8'h78, 1'b1, 1'b0);
      chk("t4_first", {24'd0, first_a}, 32'h78);
      chk("t4_pkts",  {16'd0, pkt_a},   32'd1);

      // 5: async reset mid-packet
      send(8'hAB, 1'b0, 1'b0);
      chk("t5_inpkt", {31'd0, in_pkt_a}, 32'd1);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      #2 rst_n = 1'b1;
      send(8'h9A, 1'b0, 1'b0);
      send(8'h9B, 1'b0, 1'b0);
      chk("t5_first", {24'd0, first_a}, 32'h9B);
      send(8'h00, 1'b1, 1'b0);

`ifdef FHG_SPU_EJECT_SINK_LOG_EN
      // 6: log overflow and drain
      clear = 1'b1; cycle(); clear = 1'b0;
      log_ready = 1'b0;
      for (int i = 1; i <= 6; i++) send(8'(i), 1'b1, 1'b0);
      chk("t6_ovf", {31'd0, lo_a}, 32'd1);
      for (int i = 1; i <= 4; i++) begin
         chk("t6_src", {24'd0, ls_a}, i);
         log_ready = 1'b1; cycle(); log_ready = 1'b0;
      end
      chk("t6_empty", {31'd0, lv_a}, 32'd0);
`endif

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         valid = ($urandom_range(0, 3) != 0);
         last  = ($urandom_range(0, 2) == 0);
         clear = ($urandom_range(0, 39) == 0);
         log_ready = ($urandom_range(0, 3) == 0);
         data  = {$urandom, $urandom};
         cycle();
      end
      valid = 1'b0; clear = 1'b0; log_ready = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish in time");
      $fatal(1, "timeout");
   end

endmodule
